// File: rtl/cla_arbiter.sv
// Round-robin arbiter sharing one 32-bit KPG carry-lookahead adder between two requesters.
// Optional signed-overflow output enabled by defining CLA_ARB_OVF_EN.
module cla_arbiter #(
    parameter logic [7:0] KCODE = 8'h6B,
    parameter logic [7:0] GCODE = 8'h67
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a0,
    input  logic [63:0] req_b0,
    input  logic [63:0] req_a1,
    input  logic [63:0] req_b1,
    input  logic [1:0]  req_cin,
    input  logic [1:0]  req_wide,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic [7:0]  add_xin,
    input  logic [31:0] add_sum,
    input  logic [7:0]  add_xout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_sum,
    output logic        rsp_cout,
    output logic        rsp_ovf
);

    typedef enum logic [1:0] {IDLE, LO, HI, RSP} state_t;

    state_t      state_q, state_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [63:0] sum_q, sum_d;
    logic        carry_q, carry_d;
    logic        wide_q, wide_d;
    logic        id_q, id_d;
    logic        last_q, last_d;
    logic        grant;
`ifdef CLA_ARB_OVF_EN
    logic        ovf_q, ovf_d;
`endif

    assign grant     = (&req_valid) ? ~last_q : req_valid[1];
    assign req_ready = (state_q == IDLE && req_valid[grant]) ? (2'b01 << grant) : 2'b00;

    // carry_q holds the request carry-in during LO, then the inter-pass carry during HI.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_xin = KCODE;
        if (state_q == LO || state_q == HI) begin
            add_a   = (state_q == LO) ? a_q[31:0] : a_q[63:32];
            add_b   = (state_q == LO) ? b_q[31:0] : b_q[63:32];
            add_xin = carry_q ? GCODE : KCODE;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        wide_d  = wide_q;
        id_d    = id_q;
        last_d  = last_q;
`ifdef CLA_ARB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_ready) begin
                    a_d     = grant ? req_a1 : req_a0;
                    b_d     = grant ? req_b1 : req_b0;
                    carry_d = req_cin[grant];
                    wide_d  = req_wide[grant];
                    id_d    = grant;
                    last_d  = grant;
                    state_d = LO;
                end
            end
            LO: begin
                sum_d   = {32'd0, add_sum};
                carry_d = (add_xout == GCODE);
`ifdef CLA_ARB_OVF_EN
                ovf_d   = (a_q[31] == b_q[31]) && (add_sum[31] != a_q[31]);
`endif
                state_d = wide_q ? HI : RSP;
            end
            HI: begin
                sum_d[63:32] = add_sum;
                carry_d      = (add_xout == GCODE);
`ifdef CLA_ARB_OVF_EN
                ovf_d        = (a_q[63] == b_q[63]) && (add_sum[31] != a_q[63]);
`endif
                state_d      = RSP;
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            wide_q  <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
`ifdef CLA_ARB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            wide_q  <= wide_d;
            id_q    <= id_d;
            last_q  <= last_d;
`ifdef CLA_ARB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign rsp_valid = (state_q == RSP);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry_q;
`ifdef CLA_ARB_OVF_EN
    assign rsp_ovf   = ovf_q;
`else
    assign rsp_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_cla_arbiter.sv
// Scoreboard bench for cla_arbiter with a behavioural KPG adder attached to the adder ports.
module tb_cla_arbiter;

    localparam logic [7:0] KC = 8'h6B;
    localparam logic [7:0] GC = 8'h67;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [1:0]  req_cin = '0, req_wide = '0;
    logic [31:0] add_a, add_b, add_sum;
    logic [7:0]  add_xin, add_xout;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_cout, rsp_ovf;
    logic [63:0] rsp_sum;

    always #5 clk = ~clk;

    cla_arbiter #(.KCODE(KC), .GCODE(GC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_cin(req_cin), .req_wide(req_wide),
        .add_a(add_a), .add_b(add_b), .add_xin(add_xin),
        .add_sum(add_sum), .add_xout(add_xout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
    );

    logic [32:0] add_res;
    assign add_res  = {1'b0, add_a} + {1'b0, add_b} + {32'd0, (add_xin == GC)};
    assign add_sum  = add_res[31:0];
    assign add_xout = add_res[32] ? GC : KC;

    typedef struct {
        logic        id;
        logic [63:0] a, b, sum;
        logic        cin, wide, cout, ovf, lo_c;
        int unsigned acc_n;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0, errors = 0, ncyc = 0;
    logic        exp_last = 1'b1;
    bit          front_seen = 0, chk_idle = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic wide);
        exp_t e;
        logic [32:0] n;
        logic [64:0] w;
        e.id = id; e.a = a; e.b = b; e.cin = cin; e.wide = wide; e.acc_n = 0;
        n = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'd0, cin};
        w = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        e.lo_c = n[32];
        if (wide) begin
            e.sum = w[63:0]; e.cout = w[64];
            e.ovf = (a[63] == b[63]) && (w[63] != a[63]);
        end else begin
            e.sum = {32'd0, n[31:0]}; e.cout = n[32];
            e.ovf = (a[31] == b[31]) && (n[31] != a[31]);
        end
`ifndef CLA_ARB_OVF_EN
        e.ovf = 1'b0;
`endif
        return e;
    endfunction

    exp_t        e;
    logic        g;
    int unsigned d;

    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            sb.delete();
            exp_last   = 1'b1;
            front_seen = 0;
            chk_idle   = 1;
        end else begin
            if (chk_idle) begin
                check("idle_next", {63'd0, rsp_valid}, 64'd0);
                chk_idle = 0;
            end
            if (sb.size() > 0) begin
                d = ncyc - sb[0].acc_n;
                if (d == 1) begin
                    check("lo_a", {32'd0, add_a}, {32'd0, sb[0].a[31:0]});
                    check("lo_xin", {56'd0, add_xin}, {56'd0, (sb[0].cin ? GC : KC)});
                end
                if (d == 2 && sb[0].wide) begin
                    check("hi_b", {32'd0, add_b}, {32'd0, sb[0].b[63:32]});
                    check("hi_xin", {56'd0, add_xin}, {56'd0, (sb[0].lo_c ? GC : KC)});
                end
                if (rsp_valid) begin
                    if (!front_seen) begin
                        check("latency", 64'(d), sb[0].wide ? 64'd3 : 64'd2);
                        front_seen = 1;
                    end
                    check("rsp_id", {63'd0, rsp_id}, {63'd0, sb[0].id});
                    check("rsp_sum", rsp_sum, sb[0].sum);
                    check("rsp_cout", {63'd0, rsp_cout}, {63'd0, sb[0].cout});
                    check("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, sb[0].ovf});
                    check("ready_in_rsp", {62'd0, req_ready}, 64'd0);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        front_seen = 0;
                        chk_idle   = 1;
                    end
                end
            end else begin
                if (rsp_valid) check("spurious_rsp", {63'd0, rsp_valid}, 64'd0);
            end
            if (|(req_valid & req_ready)) begin
                g = (&req_valid) ? ~exp_last : req_valid[1];
                check("grant", {62'd0, req_ready}, {62'd0, (2'b01 << g)});
                e = model(g, g ? req_a1 : req_a0, g ? req_b1 : req_b0, req_cin[g], req_wide[g]);
                e.acc_n = ncyc;
                sb.push_back(e);
                exp_last = g;
            end
        end
    end

    task automatic drive(input logic id, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic wide);
        bit got = 0;
        if (id) begin req_a1 = a; req_b1 = b; end
        else    begin req_a0 = a; req_b0 = b; end
        req_cin[id]   = cin;
        req_wide[id]  = wide;
        req_valid[id] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin got = 1; break; end
        end
        if (!got) check("req_timeout", {63'd0, req_ready[id]}, 64'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp_valid) return;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_id", {63'd0, rsp_id}, 64'd0);
        check("rst_rsp_sum", rsp_sum, 64'd0);
        check("rst_rsp_cout", {63'd0, rsp_cout}, 64'd0);
        check("rst_rsp_ovf", {63'd0, rsp_ovf}, 64'd0);
        check("rst_add_a", {32'd0, add_a}, 64'd0);
        check("rst_add_b", {32'd0, add_b}, 64'd0);
        check("rst_add_xin", {56'd0, add_xin}, {56'd0, KC});
        check("rst_req_ready", {62'd0, req_ready}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        drive(1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        wait_idle();
        drive(1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
        wait_idle();

        // Backpressure: response held five cycles in RSP.
        @(posedge clk); #1 rsp_ready = 1'b0;
        drive(1'b0, 64'h8000_0001_9000_0000, 64'h8000_0002_7000_0001, 1'b1, 1'b1);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_idle();

        // Round-robin under continuous contention from a fresh reset.
        do_reset();
        req_a0 = 64'(32'h1234_5678); req_b0 = 64'(32'h1111_1111);
        req_a1 = {$urandom, $urandom}; req_b1 = {$urandom, $urandom};
        req_cin = 2'b10; req_wide = 2'b10; req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            bit got = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (|req_ready) begin got = 1; break; end
            end
            check("rr_order", {62'd0, req_ready}, (k % 2 == 0) ? 64'd1 : 64'd2);
            if (!got) break;
            @(posedge clk); #1;
            if (k % 2 == 0) begin req_a0 = {$urandom, $urandom}; req_cin[0] = 1'($urandom); end
            else            begin req_b1 = {$urandom, $urandom}; req_wide[1] = 1'($urandom); end
        end
        req_valid = 2'b00;
        wait_idle();

        // Reset during HI aborts the op without a response.
        drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end

        drive(1'b0, 64'h0000_0000_7FFF_FFFF, 64'd1, 1'b0, 1'b0);
        wait_idle();
        drive(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
        wait_idle();

        for (int n = 0; n < 8; n++) begin
            drive(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom), 1'($urandom));
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
